// File: rtl/reg_pipe_pkg.sv
// Shared constants, the stage record and the occupancy-width helper for reg_pipe.
package reg_pipe_pkg;

    localparam int                       DEFAULT_WIDTH     = 4;
    localparam int                       DEFAULT_DEPTH     = 3;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VAL = '0;

    // Stage contents at the default word width.
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;

    // Width needed to hold a stage count of 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: a data word plus its valid bit, with reset > flush > enable priority.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_next_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Flush clears only the valid bit; the data word stays put.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (en_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Lets the parent register an occupancy count that matches the valid bits.
    assign valid_next_o = rst ? 1'b0 : valid_d;
    assign valid_o      = valid_q;
    assign data_o       = data_q;

endmodule

// File: rtl/reg_pipe.sv
// Stallable, flushable DEPTH-stage register pipeline with registered occupancy count.
// Define REG_PIPE_LATCH_TAP_EN to add the data_latch debug tap (transparent while clk is high).
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL),
    localparam int              CW        = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [CW-1:0]    count
`ifdef REG_PIPE_LATCH_TAP_EN
    ,
    output logic [WIDTH-1:0] data_latch
`endif
);

    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_valid [DEPTH];
    logic             valid_next  [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             src_valid;
            logic [WIDTH-1:0] src_data;

            if (gi == 0) begin : g_head
                assign src_valid = in_valid;
                assign src_data  = in;
            end else begin : g_link
                assign src_valid = stage_valid[gi-1];
                assign src_data  = stage_data[gi-1];
            end

            reg_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk          (clk),
                .rst          (rst),
                .flush_i      (flush),
                .en_i         (en),
                .valid_i      (src_valid),
                .data_i       (src_data),
                .valid_o      (stage_valid[gi]),
                .data_o       (stage_data[gi]),
                .valid_next_o (valid_next[gi])
            );
        end
    endgenerate

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(valid_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out       = stage_data[DEPTH-1];
    assign out_valid = stage_valid[DEPTH-1];
    assign count     = count_q;

`ifdef REG_PIPE_LATCH_TAP_EN
    logic [WIDTH-1:0] latch_q;

    always_latch begin
        if (clk) begin
            if (rst) begin
                latch_q = RESET_VAL;
            end else begin
                latch_q = in;
            end
        end
    end

    assign data_latch = latch_q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Directed vector table, randomized run against a queue model, and stall-latency sequence for reg_pipe.
module tb_reg_pipe;
    import reg_pipe_pkg::*;

    localparam int W  = 4;
    localparam int D  = 3;
    localparam int CW = count_width(D);
    localparam logic [W-1:0] RV = 4'h0;

    logic         clk = 1'b0;
    logic         rst, en, flush, in_valid;
    logic [W-1:0] in_s, out_s;
    logic         out_valid;
    logic [CW-1:0] count;
`ifdef REG_PIPE_LATCH_TAP_EN
    logic [W-1:0] data_latch;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    reg_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in        (in_s),
        .out       (out_s),
        .out_valid (out_valid),
        .count     (count)
`ifdef REG_PIPE_LATCH_TAP_EN
        ,
        .data_latch(data_latch)
`endif
    );

    // Model: queue index 0 is the newest stage, index D-1 drives out.
    stage_t pipe[$];

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < D; i++) pipe.push_back('{valid: 1'b0, data: RV});
    endtask

    task automatic model_step(input logic r, input logic f, input logic e,
                              input logic v, input logic [W-1:0] d);
        if (r) begin
            model_reset();
        end else if (f) begin
            foreach (pipe[i]) pipe[i].valid = 1'b0;
        end else if (e) begin
            pipe.push_front('{valid: v, data: d});
            void'(pipe.pop_back());
        end
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (pipe[i]) n += int'(pipe[i].valid);
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic cycle(input logic r, input logic f, input logic e,
                         input logic v, input logic [W-1:0] d);
        rst = r; flush = f; en = e; in_valid = v; in_s = d;
        @(posedge clk);
        model_step(r, f, e, v, d);
        #1;
    endtask

    typedef struct {
        logic         r, f, e, v;
        logic [W-1:0] d;
        logic [W-1:0] x_out;
        logic         x_ov;
        int           x_cnt;
    } vec_t;

    vec_t vecs[16];
    int   edges;
    logic seen;

    initial begin
        rst = 1'b1; flush = 1'b0; en = 1'b0; in_valid = 1'b0; in_s = '0;
        model_reset();

        //            r     f     e     v     d      out    ov    cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 4'h0, 1'b0, 1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 4'h0, 1'b0, 2};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'h9, 1'b1, 3};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'h9, 1'b1, 3};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'h9, 1'b1, 3};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h4, 4'h7, 1'b1, 3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 4'h7, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 4'h2, 1'b0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 4'h4, 1'b0, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 4'h1, 1'b0, 2};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 4'h3, 1'b1, 3};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 4'h6, 1'b1, 2};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 4'h0, 1'b0, 0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hC, 4'h0, 1'b0, 1};

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].r, vecs[i].f, vecs[i].e, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d_out", i),   int'(out_s),     int'(vecs[i].x_out));
            check($sformatf("vec%0d_ov", i),    int'(out_valid), int'(vecs[i].x_ov));
            check($sformatf("vec%0d_count", i), int'(count),     vecs[i].x_cnt);
            $display("vec %0d r=%0b f=%0b e=%0b v=%0b in=%0h -> out=%0h ov=%0b count=%0d",
                     i, vecs[i].r, vecs[i].f, vecs[i].e, vecs[i].v, vecs[i].d,
                     out_s, out_valid, count);
        end

        // Latency with stalls: after capture, en alternates 0,1 so DEPTH-1 enabled edges take 4 edges.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hB);
        edges = 0;
        seen  = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle(1'b0, 1'b0, logic'(k % 2), 1'b0, 4'h5);
            edges++;
            seen = out_valid;
        end
        check("stall_latency_seen", int'(seen), 1);
        check("stall_latency_edges", edges, 4);
        check("stall_latency_data", int'(out_s), 4'hB);
        $display("latency seq: out_valid after %0d edges, out=%0h", edges, out_s);

        // Randomized run against the queue model.
        for (int n = 0; n < 400; n++) begin
            logic r, f, e, v;
            logic [W-1:0] d;
            r = ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 14) == 0);
            e = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 3) != 0);
            d = W'($urandom);
            cycle(r, f, e, v, d);
            check($sformatf("rnd%0d_out", n),   int'(out_s),     int'(pipe[D-1].data));
            check($sformatf("rnd%0d_ov", n),    int'(out_valid), int'(pipe[D-1].valid));
            check($sformatf("rnd%0d_count", n), int'(count),     model_count());
            $display("rnd %0d r=%0b f=%0b e=%0b v=%0b in=%0h -> out=%0h ov=%0b count=%0d",
                     n, r, f, e, v, d, out_s, out_valid, count);
        end

`ifdef REG_PIPE_LATCH_TAP_EN
        rst = 1'b0; en = 1'b0; flush = 1'b0;
        @(negedge clk);
        in_s = 4'h9;
        @(posedge clk);
        #1;
        check("latch_follow_9", int'(data_latch), 4'h9);
        in_s = 4'h7;
        #1;
        check("latch_follow_7", int'(data_latch), 4'h7);
        @(negedge clk);
        #1;
        in_s = 4'h3;
        #1;
        check("latch_hold_7", int'(data_latch), 4'h7);
        $display("latch seq: data_latch=%0h", data_latch);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
